// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with synchronous clear, clamped parallel load,
// prescaled stepping and selectable wrap or saturate behaviour at the limits.
module updown_mod_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX      = 255,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // The prescaler needs at least one bit even when PRESCALE is 1.
  localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic             SAT      = (SATURATE != 0);

  logic [PW-1:0] pre_cnt;
  logic          step;

  // Values above MAX are clamped so later arithmetic never wraps through 2**WIDTH.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  // A step at the limit in the current direction wraps or holds.
  function automatic logic at_limit(input logic [WIDTH-1:0] c, input logic dir_up);
    return dir_up ? (c >= MAX_V) : (c == '0);
  endfunction

  function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] c,
                                                  input logic dir_up);
    logic [WIDTH-1:0] n;
    if (dir_up) begin
      if (c >= MAX_V) n = SAT ? MAX_V : '0;
      else            n = c + WIDTH'(1);
    end else begin
      if (c == '0)    n = SAT ? '0 : MAX_V;
      else            n = c - WIDTH'(1);
    end
    return n;
  endfunction

  // With PRESCALE = 1 the prescaler is stuck at 0, so every enabled cycle steps.
  assign step = en && (pre_cnt == PRE_LAST);

  // Terminal count looks only at direction and count, never at en or prescaler.
  assign tc = (up && (count == MAX_V)) || (!up && (count == '0));

  // Count, prescaler and limit pulse, prioritised reset > clear > load > step > hold.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count   <= '0;
      pre_cnt <= '0;
      ovf     <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      pre_cnt <= '0;
      ovf     <= 1'b0;
    end else if (load) begin
      count   <= clamp_load(load_val);
      pre_cnt <= '0;
      ovf     <= 1'b0;
    end else if (step) begin
      count   <= next_count(count, up);
      pre_cnt <= '0;
      ovf     <= at_limit(count, up);
    end else if (en) begin
      pre_cnt <= pre_cnt + PW'(1);
      ovf     <= 1'b0;
    end else begin
      ovf     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: four configurations share one
// stimulus bus; each phase resets all of them and checks the one it targets.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;

  logic [7:0] count_a, count_b, count_c, count_d;
  logic       tc_a, tc_b, tc_c, tc_d;
  logic       ovf_a, ovf_b, ovf_c, ovf_d;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // a: full 8-bit range, no prescale, wrap
  updown_mod_counter #(.WIDTH(8), .MAX(255), .PRESCALE(1), .SATURATE(0)) u_a (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .count(count_a), .tc(tc_a), .ovf(ovf_a));
  // b: modulo 10, no prescale, wrap
  updown_mod_counter #(.WIDTH(8), .MAX(9), .PRESCALE(1), .SATURATE(0)) u_b (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .count(count_b), .tc(tc_b), .ovf(ovf_b));
  // c: modulo 10, prescale 4, wrap
  updown_mod_counter #(.WIDTH(8), .MAX(9), .PRESCALE(4), .SATURATE(0)) u_c (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .count(count_c), .tc(tc_c), .ovf(ovf_c));
  // d: modulo 10, no prescale, saturate
  updown_mod_counter #(.WIDTH(8), .MAX(9), .PRESCALE(1), .SATURATE(1)) u_d (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .count(count_d), .tc(tc_d), .ovf(ovf_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; en = 1'b0; clear = 1'b0; load = 1'b0; up = 1'b1;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    // ---------------- reset and full up-count (a) ----------------
    reset_n = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_count", count_a, 0);
      chk("rst_ovf", ovf_a, 0);
      chk("rst_tc_up", tc_a, 0);
    end
    up = 1'b0; #1;
    chk("rst_tc_down", tc_a, 1);
    up = 1'b1;
    reset_n = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      chk("up_count", count_a, i % 256);
      chk("up_ovf", ovf_a, (i == 256) ? 1 : 0);
    end
    en = 1'b0;
    tick();
    chk("idle_ovf", ovf_a, 0);
    chk("idle_count", count_a, 0);

    // ---------------- modulo down-count (b) ----------------
    do_reset();
    up = 1'b0; en = 1'b1; #1;
    chk("down_tc0", tc_b, 1);
    for (int i = 1; i <= 11; i++) begin
      int e;
      tick();
      e = (i <= 10) ? 10 - i : 9;
      chk("down_count", count_b, e);
      chk("down_ovf", ovf_b, (i == 1 || i == 11) ? 1 : 0);
      chk("down_tc", tc_b, (e == 0) ? 1 : 0);
    end

    // ---------------- prescale (c) ----------------
    do_reset();
    up = 1'b1; en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("pre_count", count_c, i / 4);
    end
    tick(); tick();                       // prescaler now 2, count 3
    chk("pre_mid", count_c, 3);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("pre_hold", count_c, 3);
    end
    en = 1'b1;
    tick();
    chk("pre_resume1", count_c, 3);
    tick();
    chk("pre_resume2", count_c, 4);
    chk("pre_ovf", ovf_c, 0);

    // ---------------- reset mid-operation (c) ----------------
    for (int i = 0; i < 4; i++) tick();   // count 5, prescaler 0
    tick(); tick();                       // prescaler 2
    chk("mid_setup", count_c, 5);
    reset_n = 1'b0;
    tick();
    chk("mid_rst", count_c, 0);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("mid_wait", count_c, 0);
    end
    tick();
    chk("mid_step", count_c, 1);

    // ---------------- load, clamp, load priority (c) ----------------
    en = 1'b0; load = 1'b1; load_val = 8'd200;
    tick();
    chk("ld_clamp", count_c, 9);
    chk("ld_clamp_ovf", ovf_c, 0);
    load_val = 8'd5; clear = 1'b1;
    tick();
    chk("ld_clear", count_c, 0);
    clear = 1'b0; load_val = 8'd9;
    tick();
    chk("ld_nine", count_c, 9);
    load = 1'b0; en = 1'b1;
    tick(); tick(); tick();               // step now pending, would wrap
    chk("ld_pend", count_c, 9);
    load = 1'b1; load_val = 8'd9;
    tick();
    chk("ld_step_count", count_c, 9);
    chk("ld_step_ovf", ovf_c, 0);
    load = 1'b0;
    tick(); tick(); tick();
    chk("ld_pre_reset", count_c, 9);
    tick();
    chk("ld_wrap_count", count_c, 0);
    chk("ld_wrap_ovf", ovf_c, 1);

    // ---------------- saturate (d) ----------------
    do_reset();
    load = 1'b1; load_val = 8'd7;
    tick();
    chk("sat_load", count_d, 7);
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("sat_up_count", count_d, (i == 1) ? 8 : 9);
      chk("sat_up_ovf", ovf_d, (i >= 3) ? 1 : 0);
    end
    up = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("sat_dn_count", count_d, (i <= 9) ? 9 - i : 0);
      chk("sat_dn_ovf", ovf_d, (i >= 10) ? 1 : 0);
    end
    en = 1'b0;
    tick();
    chk("sat_idle_ovf", ovf_d, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
